// File: rtl/comp_merge_pkg.sv
// comp_merge_pkg
// Shared definitions for the compensation result merger:
//   - default array geometry and datapath widths
//   - the merger FSM state enum
//   - output clip bounds, with helper functions so a re-parameterised
//     instance derives matching bounds from its own OUT_W
package comp_merge_pkg;

  localparam int COLS   = 8;
  localparam int ROWS   = 8;
  localparam int PSUM_W = 24;
  localparam int COMP_W = 22;
  localparam int SHIFT  = 4;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    EMIT     = 2'd2
  } merge_state_e;

  function automatic int clip_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int clip_min(int w);
    return -(1 << (w - 1));
  endfunction

  localparam int OUT_MAX = clip_max(OUT_W);
  localparam int OUT_MIN = clip_min(OUT_W);

endpackage

// File: rtl/comp_merge_scale.sv
// comp_merge_scale
// Purely combinational per-column merge: adds the unsigned compensation
// sum to the signed partial sum, optionally rounds (half up), arithmetic
// shifts right by SHIFT and saturates to a signed OUT_W result.
// Optional feature macro: COMP_MERGE_ROUND_EN (adds 2^(SHIFT-1) before
// the shift; otherwise plain floor truncation).
// Ports:
//   psum  in   PSUM_W  signed partial sum
//   comp  in   COMP_W  unsigned compensation sum
//   data  out  OUT_W   signed merged, clipped result
//   sat   out  1       data was clipped
module comp_merge_scale
  import comp_merge_pkg::*;
#(
  parameter int PSUM_W = comp_merge_pkg::PSUM_W,
  parameter int COMP_W = comp_merge_pkg::COMP_W,
  parameter int SHIFT  = comp_merge_pkg::SHIFT,
  parameter int OUT_W  = comp_merge_pkg::OUT_W
) (
  input  logic [PSUM_W-1:0] psum,
  input  logic [COMP_W-1:0] comp,
  output logic [OUT_W-1:0]  data,
  output logic              sat
);

  // Two guard bits: one for the psum+comp add, one for the rounding add.
  localparam int SUM_W = PSUM_W + 2;
  localparam logic signed [SUM_W-1:0] HI = SUM_W'(clip_max(OUT_W));
  localparam logic signed [SUM_W-1:0] LO = SUM_W'(clip_min(OUT_W));

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] rounded;
  logic signed [SUM_W-1:0] shifted;

  assign sum = {{2{psum[PSUM_W-1]}}, psum}
             + {2'b00, {(PSUM_W - COMP_W){1'b0}}, comp};

`ifdef COMP_MERGE_ROUND_EN
  assign rounded = sum + (SUM_W'(1) << (SHIFT - 1));
`else
  assign rounded = sum;
`endif

  // Arithmetic shift of a negative value floors toward -infinity.
  assign shifted = rounded >>> SHIFT;

  // NOTE: both outputs get a default before the if-chain so no path leaves
  // them unassigned, which would otherwise infer a latch.
  always_comb begin
    data = shifted[OUT_W-1:0];
    sat  = 1'b0;
    if (shifted > HI) begin
      data = HI[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < LO) begin
      data = LO[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/comp_result_merger.sv
// comp_result_merger
// Latches a tile's final per-column compensation sums, then for each of
// ROWS rows of partial sums emits COLS merged results (psum + comp,
// rescaled, rounded, saturated) one column per beat on a valid/ready stream.
// Optional feature macro: COMP_MERGE_ROUND_EN (see comp_merge_scale).
// Ports:
//   clk, rst (async, active-high)
//   comp_load, comp_vec          compensation strobe and packed sums
//   psum_valid/psum_ready/psum_vec  row input stream
//   out_valid/out_ready          result beat stream
//   out_data, out_col, out_sat, out_last  beat payload
//   tile_done                    pulse after the last beat is accepted
//   err_overlap                  sticky: comp_load seen outside IDLE
module comp_result_merger
  import comp_merge_pkg::*;
#(
  parameter int COLS   = comp_merge_pkg::COLS,
  parameter int ROWS   = comp_merge_pkg::ROWS,
  parameter int PSUM_W = comp_merge_pkg::PSUM_W,
  parameter int COMP_W = comp_merge_pkg::COMP_W,
  parameter int SHIFT  = comp_merge_pkg::SHIFT,
  parameter int OUT_W  = comp_merge_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     comp_load,
  input  logic [COLS*COMP_W-1:0]   comp_vec,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic [COLS*PSUM_W-1:0]   psum_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic                     out_sat,
  output logic                     out_last,
  output logic                     tile_done,
  output logic                     err_overlap
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  merge_state_e state_q, state_d;

  logic [COLS*COMP_W-1:0] comp_reg;
  logic [COLS*PSUM_W-1:0] row_reg;
  logic [COL_W-1:0]       col_cnt;
  logic [ROW_W-1:0]       row_cnt;

  logic row_hs, beat, col_end, row_end;

  assign psum_ready = (state_q == WAIT_ROW);
  assign out_valid  = (state_q == EMIT);
  assign row_hs     = psum_valid && psum_ready;
  assign beat       = out_valid && out_ready;
  assign col_end    = (col_cnt == COL_LAST);
  assign row_end    = (row_cnt == ROW_LAST);
  assign out_col    = col_cnt;
  // Gated by EMIT so the counters parked at their last values after a tile
  // do not leave out_last asserted in IDLE.
  assign out_last   = out_valid && col_end && row_end;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (comp_load) state_d = WAIT_ROW;
      WAIT_ROW: if (row_hs)    state_d = EMIT;
      EMIT:     if (beat && col_end) state_d = row_end ? IDLE : WAIT_ROW;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the wide comp/row registers are reset too: a mid-tile reset must
  // drive out_data (derived from them) back to 0, not to stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_reg    <= '0;
      row_reg     <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      tile_done   <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      if (comp_load) begin
        if (state_q == IDLE) begin
          comp_reg <= comp_vec;
          row_cnt  <= '0;
        end else begin
          err_overlap <= 1'b1;
        end
      end
      if (row_hs) begin
        row_reg <= psum_vec;
        col_cnt <= '0;
      end
      if (beat) begin
        if (!col_end)      col_cnt <= col_cnt + COL_W'(1);
        else if (!row_end) row_cnt <= row_cnt + ROW_W'(1);
      end
      tile_done <= beat && col_end && row_end;
    end
  end

  logic [PSUM_W-1:0] sel_psum;
  logic [COMP_W-1:0] sel_comp;

  assign sel_psum = row_reg[col_cnt*PSUM_W +: PSUM_W];
  assign sel_comp = comp_reg[col_cnt*COMP_W +: COMP_W];

  comp_merge_scale #(
    .PSUM_W (PSUM_W),
    .COMP_W (COMP_W),
    .SHIFT  (SHIFT),
    .OUT_W  (OUT_W)
  ) u_scale (
    .psum (sel_psum),
    .comp (sel_comp),
    .data (out_data),
    .sat  (out_sat)
  );

endmodule
